// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with fixed-priority and round-robin modes.
// The winner is held on a valid/ready output until it is accepted.
module rr_priority_arbiter #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            mode,
    output logic            gnt_valid,
    input  logic            gnt_ready,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot,
    output logic            req_pending
);
    localparam logic [IDXW-1:0] TOP = IDXW'(N - 1);

    logic            accept;
    logic            load_en;
    logic [N-1:0]    cand;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] start;
    logic [IDXW-1:0] winner;
    logic            found;

    assign accept  = gnt_valid & gnt_ready;
    assign load_en = ~gnt_valid | accept;
    // The requester being accepted this edge is never re-granted on the same edge.
    assign cand    = req & ~(accept ? gnt_onehot : '0);

    always_comb begin
        if (!mode)
            start = TOP;
        else if (accept)
            start = (gnt_idx == '0) ? TOP : gnt_idx - IDXW'(1);
        else
            start = rr_ptr;
    end

    // Descending search from start, wrapping from 0 back to N-1.
    always_comb begin : search
        int pos;
        pos    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) - k;
            if (pos < 0)
                pos = pos + N;
            if (!found && cand[IDXW'(pos)]) begin
                found  = 1'b1;
                winner = IDXW'(pos);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_valid   <= 1'b0;
            gnt_idx     <= '0;
            gnt_onehot  <= '0;
            req_pending <= 1'b0;
            rr_ptr      <= TOP;
        end else begin
            req_pending <= |req;
            if (accept)
                rr_ptr <= start;
            if (load_en) begin
                if (found) begin
                    gnt_valid  <= 1'b1;
                    gnt_idx    <= winner;
                    gnt_onehot <= N'(1) << winner;
                end else begin
                    // gnt_idx keeps its last value so it never goes undefined.
                    gnt_valid  <= 1'b0;
                    gnt_onehot <= '0;
                end
            end
        end
    end
endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
Parametrised, registered successor to the 4-to-2 combinational priority encoder. It accepts N level-sensitive request lines and selects one winner per transaction. Two modes are supported: fixed priority, where the highest index wins, and round-robin, where a rotating pointer starts the search. The winner is presented on a valid/ready output interface. It sits between requesting agents and a shared downstream resource such as a bus port or a shared FIFO write side.

Parameters:
N, 8, number of requesters (N >= 2)
IDXW, $clog2(N), width of the encoded grant index (derived; do not override)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
req  input  N  level requests; bit i high = requester i wants service; held until its grant is accepted
mode  input  1  0 = fixed priority (index N-1 highest); 1 = round-robin
gnt_valid  output  1  a grant is held on gnt_idx/gnt_onehot
gnt_ready  input  1  downstream accepts the current grant
gnt_idx  output  IDXW  binary index of the granted requester
gnt_onehot  output  N  one-hot form of gnt_idx; all zeros when gnt_valid = 0
req_pending  output  1  registered OR of req; high when any request was present in the previous cycle

Behaviour:
- Reset (rst_n = 0 at a clock edge): gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0, req_pending = 0, rr_ptr = N-1. Reset has priority over all other activity. A held grant is discarded, and no accept is signalled for it.
- accept = gnt_valid & gnt_ready.
- load_en = ~gnt_valid | accept. The output register is empty or being drained this cycle.
- Masked candidate set: cand = req & ~(accept ? gnt_onehot : 0). The requester just accepted is never re-granted in the same edge, even if its req is still high.
- Search start:
  - mode = 0: start = N-1.
  - mode = 1: start = accept ? (gnt_idx == 0 ? N-1 : gnt_idx-1) : rr_ptr.
- Search order: descending from start, wrapping N-1 after 0. The first set bit of cand in that order is the winner.
- Clock edge with load_en = 1:
  - If cand != 0: gnt_valid <= 1, gnt_idx <= winner, gnt_onehot <= 1 << winner.
  - If cand == 0: gnt_valid <= 0, gnt_onehot <= 0, gnt_idx holds its value.
- Clock edge with load_en = 0: all grant outputs hold. A grant is stable while gnt_valid = 1 and gnt_ready = 0. req changes, including deassertion of the granted bit, do not alter a held grant.
- rr_ptr <= start whenever accept = 1, in either mode. This keeps round-robin fair after a mode switch. Otherwise rr_ptr holds.
- Latency: a request arriving at an idle arbiter appears on gnt_valid at the next edge (1 cycle).
- Back-to-back throughput: with gnt_ready tied high and continuous requests, one grant per cycle.
- mode may change at any cycle. The change affects only the next load; a held grant is unaffected.
- Simultaneous events:
  - Accept and new requests in the same cycle: new winner loaded the same edge, no bubble.
  - Accept with no other requests: gnt_valid falls the next edge.
- req_pending <= |req every cycle (except reset).
- Fixed mode with N = 4 reproduces the legacy encoder mapping: req 1xxx -> idx 3, 01xx -> 2, 001x -> 1, 0001 -> 0. It is registered, with valid qualified by handshake.
- No X propagation: gnt_idx and gnt_onehot are always defined after reset.
- Assertions the bench must carry:
  - $onehot0(gnt_onehot).
  - gnt_onehot == 0 iff gnt_valid == 0.
  - Grant stable while gnt_valid & ~gnt_ready.

Test Plan:
1. N=4, mode=0, gnt_ready=1, req=4'b1010 held. Required response:
   - Every cycle gnt_idx alternates 3, 1, 3, 1.
   - This follows from the same-edge mask plus the re-search from N-1.
2. N=4, mode=1, gnt_ready=1, req=4'b1111 held for 8 cycles. Required response:
   - gnt_idx sequence 3, 2, 1, 0, 3, 2, 1, 0.
   - gnt_valid stays high throughout.
3. N=4, mode=1, req=4'b0110, gnt_ready=0 for 3 cycles, then 1. Required response:
   - gnt_idx=2 held stable for 3 cycles.
   - After the accept, gnt_idx=1 the next cycle and rr_ptr=1.
4. N=8, mode=0, idle, then a single-cycle pulse req=8'h20 with gnt_ready=0 until the grant is seen, then 1. Required response:
   - gnt_valid=1 and gnt_idx=5 one edge after the pulse.
   - The grant holds after req drops.
   - gnt_valid returns to 0 one edge after the accept.
5. rst_n=0 for one edge while gnt_valid=1, gnt_idx=2. Required response:
   - gnt_valid=0, gnt_onehot=0, gnt_idx=0, req_pending=0 after that edge.
   - The next round-robin search restarts from index N-1.
6. mode toggled 1 -> 0 mid-stream with req=4'b1111, rr_ptr=1. Required response:
   - The next load grants idx 3, not 1.
   - On return to mode=1 after accepting 3, the search starts at 2.
